// File: rtl/dmem_responder.sv
// dmem_responder: single-cycle data-memory responder for a small core.
// Word-addressed RAM plus a 16-byte MMIO window (GPIO, CYCLE, TOHOST, STATUS).
// Loads are combinational; stores commit on the clock edge with no stall.
// Optional feature macro: DMEM_CYCLE_CNT_EN (free-running cycle counter).
// Without it, CYCLE reads as zero and no counter flops exist.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_we,
    input  logic        data_re,
    output logic [31:0] data_rdata,
    output logic [7:0]  gpio_out,
    output logic        halt,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  gpio_q, gpio_d;
    logic [31:0] tohost_q, tohost_d;
    logic        err_q, err_d;
    logic [31:0] cycle_val;

    // RAM contents survive reset, so the array has no reset branch.
    logic [31:0] mem [DEPTH_WORDS];

    // Address decode. RAM wins if a badly chosen MMIO_BASE ever overlaps it.
    logic          ram_hit;
    logic          mmio_hit;
    logic          mmio_sel;
    logic          bad_addr;
    logic          running;
    logic          wr_ok;
    logic [1:0]    mmio_off;
    logic [AW-1:0] word_idx;

    assign ram_hit  = (data_addr[31:AW+2] == '0);
    assign mmio_hit = (data_addr[31:4] == MMIO_BASE[31:4]);
    assign mmio_sel = mmio_hit && !ram_hit;
    assign bad_addr = (data_addr[1:0] != 2'b00) || !(ram_hit || mmio_hit);
    assign mmio_off = data_addr[3:2];
    assign word_idx = data_addr[AW+1:2];
    assign running  = (state_q == ST_RUN);
    // A store only takes effect when mapped, aligned and not halted.
    assign wr_ok    = data_we && running && !bad_addr;

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cycle_q, cycle_d;

    // Cycle counter advances while running, freezes in HALT, wraps naturally.
    always_comb begin
        cycle_d = running ? cycle_q + 32'd1 : cycle_q;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle_q <= '0;
        else        cycle_q <= cycle_d;
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    // Combinational load path; reads see pre-write state in the same cycle.
    always_comb begin
        data_rdata = '0;
        if (data_re) begin
            if (bad_addr) begin
                data_rdata = 32'hDEAD_BEEF;
            end else if (ram_hit) begin
                data_rdata = mem[word_idx];
            end else begin
                case (mmio_off)
                    2'd0:    data_rdata = {24'd0, gpio_q};
                    2'd1:    data_rdata = cycle_val;
                    2'd2:    data_rdata = tohost_q;
                    default: data_rdata = {30'd0, err_q, (state_q == ST_HALT)};
                endcase
            end
        end
    end

    // Next-state for FSM, MMIO registers and the sticky error flag.
    always_comb begin
        state_d  = state_q;
        gpio_d   = gpio_q;
        tohost_d = tohost_q;
        // Dropped stores in HALT are silent; bad loads are still flagged.
        err_d    = err_q | (bad_addr && (data_re || (data_we && running)));
        if (wr_ok && mmio_sel) begin
            case (mmio_off)
                2'd0: gpio_d = data_wdata[7:0];
                2'd2: begin
                    tohost_d = data_wdata;
                    state_d  = ST_HALT;
                end
                default: ;  // CYCLE and STATUS are read-only, writes ignored
            endcase
        end
    end

    // State and MMIO registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            gpio_q   <= '0;
            tohost_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gpio_q   <= gpio_d;
            tohost_q <= tohost_d;
            err_q    <= err_d;
        end
    end

    // RAM store port; nothing commits while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok && ram_hit) mem[word_idx] <= data_wdata;
    end

    assign gpio_out = gpio_q;
    assign halt     = (state_q == ST_HALT);
    assign err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder with a behavioural model of the memory map.
module tb_dmem_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] MB    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_we = 1'b0;
    logic        data_re = 1'b0;
    logic [31:0] data_rdata;
    logic [7:0]  gpio_out;
    logic        halt;
    logic        err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
        .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_we(data_we), .data_re(data_re), .data_rdata(data_rdata),
        .gpio_out(gpio_out), .halt(halt), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_mem [DEPTH];
    logic [7:0]  m_gpio;
    logic [31:0] m_tohost;
    logic [31:0] m_cycle;
    logic        m_halt;
    logic        m_err;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    function automatic bit is_ram(logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic bit is_mmio(logic [31:0] a);
        return (a - MB) < 32'd16;
    endfunction

    function automatic bit is_bad(logic [31:0] a);
        return (a[1:0] != 2'b00) || !(is_ram(a) || is_mmio(a));
    endfunction

    function automatic logic [31:0] exp_cycle();
`ifdef DMEM_CYCLE_CNT_EN
        return m_cycle;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_rd();
        logic [31:0] a;
        a = data_addr;
        if (!data_re)   return 32'd0;
        if (is_bad(a))  return 32'hDEAD_BEEF;
        if (is_ram(a))  return m_mem[a >> 2];
        case (a - MB)
            32'h0:   return {24'd0, m_gpio};
            32'h4:   return exp_cycle();
            32'h8:   return m_tohost;
            default: return {30'd0, m_err, m_halt};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (addr=%h we=%0b re=%0b t=%0t)",
                     nm, act, exp, data_addr, data_we, data_re, $time);
        end
    endtask

    task automatic model_reset();
        m_gpio   = '0;
        m_tohost = '0;
        m_cycle  = '0;
        m_halt   = 1'b0;
        m_err    = 1'b0;
    endtask

    // Apply one clock edge's worth of effects to the model.
    task automatic model_edge();
        logic [31:0] a;
        bit bad, nh;
        if (!rst_n) return;
        a   = data_addr;
        bad = is_bad(a);
        nh  = m_halt;
        if (bad && (data_re || (data_we && !m_halt))) m_err = 1'b1;
        if (!m_halt && data_we && !bad) begin
            if (is_ram(a)) m_mem[a >> 2] = data_wdata;
            else if (a - MB == 32'h0) m_gpio = data_wdata[7:0];
            else if (a - MB == 32'h8) begin
                m_tohost = data_wdata;
                nh = 1'b1;
            end
        end
        if (!m_halt) m_cycle = m_cycle + 32'd1;
        m_halt = nh;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rdata", data_rdata, exp_rd());
            chk("gpio", {24'd0, gpio_out}, {24'd0, m_gpio});
            chk("halt", {31'd0, halt}, {31'd0, m_halt});
            chk("err", {31'd0, err}, {31'd0, m_err});
        end
    end

    task automatic set_in(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd);
        data_we    = we;
        data_re    = re;
        data_addr  = a;
        data_wdata = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // One random transaction; bad stores are suppressed when allow_bad_wr is 0.
    task automatic rand_txn(input bit allow_bad, input bit allow_bad_wr, input bit allow_tohost_wr);
        logic        we, re;
        logic [31:0] a;
        int r;
        we = 1'($urandom);
        re = 1'($urandom);
        r  = $urandom_range(0, 99);
        if (r < 60)      a = 32'($urandom_range(3, DEPTH - 1)) << 2;
        else if (r < 70) a = MB;
        else if (r < 77) a = MB + 32'h4;
        else if (r < 84) a = MB + 32'hC;
        else if (r < 90) a = MB + 32'h8;
        else if (r < 95) a = (32'($urandom_range(3, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        else             a = (r[0]) ? MB + 32'h10 : 32'h0001_0000 + (32'($urandom_range(0, 255)) << 2);
        if (a == MB + 32'h8 && !allow_tohost_wr) we = 1'b0;
        if (is_bad(a) && !allow_bad) a = 32'($urandom_range(3, DEPTH - 1)) << 2;
        if (is_bad(a) && !allow_bad_wr) we = 1'b0;
        set_in(we, re, a, $urandom);
        tick();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        set_in(1'b1, 1'b0, 32'h0, 32'h0000_0BAD);  // must not commit during reset
        tick();
        tick();
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        cmp_en = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("reset_gpio", {24'd0, gpio_out}, 32'h0);
        chk("reset_halt", {31'd0, halt}, 32'h0);
        chk("reset_err", {31'd0, err}, 32'h0);
        chk("reset_rdata", data_rdata, 32'h0);
        rst_n = 1'b1;

        // Fill RAM so model and DUT agree on every word
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 1'b0, 32'(i) << 2, (i == 2) ? 32'hCAFE_0002 : $urandom);
            tick();
        end

        // Store then load word 0
        set_in(1'b1, 1'b0, 32'h0, 32'h0000_001E); tick();
        set_in(1'b0, 1'b1, 32'h0, 32'h0);
        #2 chk("lw_after_sw", data_rdata, 32'h0000_001E);
        chk("lw_err", {31'd0, err}, 32'h0);
        tick();

        // Simultaneous read/write returns old data
        set_in(1'b1, 1'b0, 32'h4, 32'h0000_0011); tick();
        set_in(1'b1, 1'b1, 32'h4, 32'h0000_0022);
        #2 chk("rmw_old", data_rdata, 32'h0000_0011);
        tick();
        set_in(1'b0, 1'b1, 32'h4, 32'h0);
        #2 chk("rmw_new", data_rdata, 32'h0000_0022);
        tick();

        // GPIO write and readback
        set_in(1'b1, 1'b0, MB, 32'h0000_00A5); tick();
        chk("gpio_out", {24'd0, gpio_out}, 32'h0000_00A5);
        set_in(1'b0, 1'b1, MB, 32'h0);
        #2 chk("gpio_rd", data_rdata, 32'h0000_00A5);
        tick();

        // Clean random traffic
        for (int i = 0; i < 1000; i++) rand_txn(1'b0, 1'b0, 1'b0);

        // Reset mid-program: registers clear, RAM kept
        pulse_reset();
        set_in(1'b0, 1'b1, MB + 32'h4, 32'h0);
        #2 chk("cycle_after_rst", data_rdata, 32'h0);
        chk("gpio_after_rst", {24'd0, gpio_out}, 32'h0);
        tick();
        set_in(1'b0, 1'b1, 32'h0, 32'h0);
        #2 chk("ram0_after_rst", data_rdata, 32'h0000_001E);
        tick();

        // Bus errors: misaligned read, out-of-range and misaligned stores
        set_in(1'b0, 1'b1, 32'h2, 32'h0);
        #2 chk("misaligned_rd", data_rdata, 32'hDEAD_BEEF);
        tick();
        chk("err_set", {31'd0, err}, 32'h1);
        set_in(1'b1, 1'b0, 32'(DEPTH * 4), 32'h1234_5678); tick();
        set_in(1'b1, 1'b0, 32'h1, 32'h1234_5678); tick();
        set_in(1'b0, 1'b1, 32'h0, 32'h0);
        #2 chk("ram0_unchanged", data_rdata, 32'h0000_001E);
        chk("err_sticky", {31'd0, err}, 32'h1);
        tick();

        // Random traffic including bad accesses
        for (int i = 0; i < 1000; i++) rand_txn(1'b1, 1'b1, 1'b0);

        // Halt sequence from a clean reset
        pulse_reset();
        tick();
        set_in(1'b1, 1'b0, MB + 32'h8, 32'h0000_0001); tick();
        chk("halt_set", {31'd0, halt}, 32'h1);
        set_in(1'b0, 1'b1, MB + 32'hC, 32'h0);
        #2 chk("status_rd", data_rdata, 32'h0000_0001);
        tick();
        set_in(1'b0, 1'b1, MB + 32'h8, 32'h0);
        #2 chk("tohost_rd", data_rdata, 32'h0000_0001);
        tick();
        set_in(1'b1, 1'b0, 32'h8, 32'h0000_FFFF); tick();
        set_in(1'b0, 1'b1, 32'h8, 32'h0);
        #2 chk("halt_ram_kept", data_rdata, 32'hCAFE_0002);
        tick();
        set_in(1'b0, 1'b1, MB + 32'h4, 32'h0); tick(); tick();

        // Random traffic while halted: stores dropped, loads served
        for (int i = 0; i < 300; i++) rand_txn(1'b1, 1'b0, 1'b1);

        set_in(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
